ram8: RTL and testbench



---
 rtl/ram8_pkg.sv | 10 +
 rtl/ram8_cells.sv | 66 ++++++
 rtl/ram8.sv | 68 ++++++
 tb/tb_ram8.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
// rtl/ram8_pkg.sv - shared sizes and reset value for the RAM hierarchy
//
// Purpose: widths, depth and reset word shared by ram8 and larger RAMs
// built from it. No ports.
package ram8_pkg;
  localparam int RAM_WIDTH   = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 8;
  localparam logic [RAM_WIDTH-1:0] RAM_RST = 16'h0000;
endpackage

// File: rtl/ram8_cells.sv
// rtl/ram8_cells.sv - storage register and 8-way read selector
//
// register16: load-enable D register with synchronous active-high reset.
//   clk   : clock, rising edge
//   reset : synchronous clear to RAM_RST, wins over load
//   in    : data to capture
//   load  : capture enable
//   out   : stored word
// mux8way16: combinational 8-to-1 word selector.
//   a..h  : candidate words, a selected by sel=0 through h by sel=7
//   sel   : select
//   out   : selected word
module register16
  import ram8_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RAM_WIDTH-1:0] in,
  input  logic                 load,
  output logic [RAM_WIDTH-1:0] out
);
  logic [RAM_WIDTH-1:0] data_q;
  logic [RAM_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = in;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= RAM_RST;
    else       data_q <= data_d;
  end

  assign out = data_q;
endmodule

module mux8way16
  import ram8_pkg::*;
(
  input  logic [RAM_WIDTH-1:0]   a,
  input  logic [RAM_WIDTH-1:0]   b,
  input  logic [RAM_WIDTH-1:0]   c,
  input  logic [RAM_WIDTH-1:0]   d,
  input  logic [RAM_WIDTH-1:0]   e,
  input  logic [RAM_WIDTH-1:0]   f,
  input  logic [RAM_WIDTH-1:0]   g,
  input  logic [RAM_WIDTH-1:0]   h,
  input  logic [RAM8_ADDR_W-1:0] sel,
  output logic [RAM_WIDTH-1:0]   out
);
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end
endmodule

// File: rtl/ram8.sv
// rtl/ram8.sv - 8 x 16 register RAM with combinational read
//
// dmux8way: routes one load line to the output selected by sel (one-hot).
//   in    : load request
//   sel   : target line
//   out   : eight load lines, at most one high
// ram8: eight register16 words, write on load, read through mux8way16.
//   clk     : clock, rising edge
//   reset   : synchronous active-high, clears every word, beats load
//   in      : write data
//   load    : write enable for mem[address]
//   address : word select for read and write
//   out     : mem[address], combinational (no write-through)
module dmux8way
  import ram8_pkg::*;
(
  input  logic                   in,
  input  logic [RAM8_ADDR_W-1:0] sel,
  output logic [RAM8_DEPTH-1:0]  out
);
  always_comb begin
    out      = '0;
    out[sel] = in;
  end
endmodule

module ram8
  import ram8_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RAM_WIDTH-1:0]   in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [RAM_WIDTH-1:0]   out
);
  logic [RAM8_DEPTH-1:0] load_line;
  logic [RAM_WIDTH-1:0]  word [RAM8_DEPTH];

  dmux8way u_dmux (
    .in  (load),
    .sel (address),
    .out (load_line)
  );

  for (genvar i = 0; i < RAM8_DEPTH; i++) begin : g_word
    register16 u_reg (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .load  (load_line[i]),
      .out   (word[i])
    );
  end

  mux8way16 u_mux (
    .a   (word[0]),
    .b   (word[1]),
    .c   (word[2]),
    .d   (word[3]),
    .e   (word[4]),
    .f   (word[5]),
    .g   (word[6]),
    .h   (word[7]),
    .sel (address),
    .out (out)
  );
endmodule

// File: tb/tb_ram8.sv
// tb/tb_ram8.sv - self-checking bench for ram8
module tb_ram8;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = 16'h0000;
  logic        load = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [15:0] dout;

  int total = 0;
  int bad = 0;

  logic [15:0] model [8];

  always #5 clk = ~clk;

  ram8 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .load    (load),
    .address (address),
    .out     (dout)
  );

  typedef struct {
    bit        rst;
    bit        ld;
    bit [2:0]  a;
    bit [15:0] d;
    bit [15:0] exp;
    string     name;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [15:0] exp);
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, dout, exp);
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit [2:0] a, input bit [15:0] d);
    @(negedge clk);
    reset = r;
    load = l;
    address = a;
    din = d;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input bit [2:0] a, input string name, input logic [15:0] exp);
    @(negedge clk);
    reset = 1'b0;
    load = 1'b0;
    address = a;
    #1;
    chk(name, exp);
  endtask

  function automatic vec_t mk(bit r, bit l, bit [2:0] a, bit [15:0] d, bit [15:0] e, string n);
    vec_t v;
    v.rst = r; v.ld = l; v.a = a; v.d = d; v.exp = e; v.name = n;
    return v;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 3'd0, 16'h0000);
    edge_settle();

    for (int k = 0; k < 8; k++) read_at(k[2:0], "reset_sweep", 16'h0000);

    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b0, 1'b1, k[2:0], 16'h1000 + 16'(k), 16'h1000 + 16'(k), "write_k"));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b0, 1'b0, k[2:0], 16'hFFFF, 16'h1000 + 16'(k), "hold_ffff"));
    vecs.push_back(mk(1'b0, 1'b1, 3'd2, 16'h0001, 16'h0001, "toggle_2a"));
    vecs.push_back(mk(1'b0, 1'b1, 3'd6, 16'h0002, 16'h0002, "toggle_6"));
    vecs.push_back(mk(1'b0, 1'b1, 3'd2, 16'h0003, 16'h0003, "toggle_2b"));
    vecs.push_back(mk(1'b0, 1'b0, 3'd6, 16'h0000, 16'h0002, "final_6"));
    vecs.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0000, 16'h0003, "final_2"));
    vecs.push_back(mk(1'b0, 1'b1, 3'd7, 16'h00AA, 16'h00AA, "b2b_7a"));
    vecs.push_back(mk(1'b0, 1'b1, 3'd7, 16'h00BB, 16'h00BB, "b2b_7b"));
    vecs.push_back(mk(1'b0, 1'b1, 3'd3, 16'h1234, 16'h1234, "pre_rw_3"));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].a, vecs[i].d);
      edge_settle();
      chk(vecs[i].name, vecs[i].exp);
    end

    drive(1'b0, 1'b1, 3'd3, 16'hBEEF);
    #1;
    chk("rw_before_edge", 16'h1234);
    edge_settle();
    chk("rw_after_edge", 16'hBEEF);

    read_at(3'd0, "cross_0", 16'h1000);
    read_at(3'd5, "cross_5", 16'h1005);
    read_at(3'd7, "cross_7", 16'h00BB);

    drive(1'b1, 1'b1, 3'd5, 16'hAAAA);
    edge_settle();
    for (int k = 0; k < 8; k++) read_at(k[2:0], "reset_during_write", 16'h0000);

    drive(1'b0, 1'b1, 3'd5, 16'h5555);
    edge_settle();
    chk("first_after_reset", 16'h5555);

    for (int k = 0; k < 8; k++) model[k] = 16'h0000;
    model[5] = 16'h5555;
    for (int n = 0; n < 300; n++) begin
      bit        r;
      bit        l;
      bit [2:0]  a;
      bit [15:0] d;
      r = ($urandom_range(0, 31) == 0);
      l = $urandom_range(0, 1) == 1;
      a = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      drive(r, l, a, d);
      #1;
      chk("rand_before", model[a]);
      if (r) begin
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;
      end else if (l) begin
        model[a] = d;
      end
      edge_settle();
      chk("rand_after", model[a]);
    end

    for (int k = 0; k < 8; k++) read_at(k[2:0], "rand_final", model[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
